// File: rtl/macarray_pkg.sv
// Shared constants, MNT field layout and sequencer state encoding for the 4x4 MAC array.
package macarray_pkg;

  localparam int unsigned DW     = 8;
  localparam int unsigned AW     = 16;
  localparam int unsigned LAT    = 1;
  localparam int unsigned TILE   = 4;
  localparam int unsigned MAXDIM = 8;

  localparam int unsigned HALF_W = TILE * DW;
  localparam int unsigned ROW_W  = TILE * AW;

  localparam int unsigned DIM_W  = 4;
  localparam int unsigned M_LSB  = 8;
  localparam int unsigned N_LSB  = 4;
  localparam int unsigned T_LSB  = 0;

  // RD issues TILE reads; the last lane lands LAT cycles after the last read.
  localparam int unsigned RD_LAST = TILE - 1 + LAT;
  localparam int unsigned WR_LAST = TILE - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RD,
    S_ACC,
    S_WR,
    S_DONE
  } state_t;

  // A dimension is legal when it lies in 1..MAXDIM.
  function automatic logic dim_ok(input logic [DIM_W-1:0] d);
    return (d != '0) && (d <= DIM_W'(MAXDIM));
  endfunction

endpackage

// File: rtl/mac_sched_mask.sv
// Combinational masking of array lane data and result rows against the latched M/N/T.
module mac_sched_mask
  import macarray_pkg::*;
(
  input  logic [11:0] mnt_i,
  input  logic        ti_i,
  input  logic        mi_i,
  input  logic        kh_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  row_i,
  input  logic        ld_i,
  input  logic        wr_i,
  input  logic [31:0] rd_in_i,
  input  logic [31:0] rd_wt_i,
  input  logic [63:0] row_data_i,
  output logic [31:0] in_data_o,
  output logic [31:0] wt_data_o,
  output logic [63:0] wdata_o
);

  logic [DIM_W-1:0] m_dim;
  logic [DIM_W-1:0] n_dim;
  logic [DIM_W-1:0] t_dim;

  assign m_dim = mnt_i[M_LSB +: DIM_W];
  assign n_dim = mnt_i[N_LSB +: DIM_W];
  assign t_dim = mnt_i[T_LSB +: DIM_W];

  // Lane data passes only for rows/columns inside the matrix, bytes only inside N.
  always_comb begin
    in_data_o = '0;
    wt_data_o = '0;
    if (ld_i) begin
      if ({1'b0, ti_i, lane_i} < t_dim) in_data_o = rd_in_i;
      if ({1'b0, mi_i, lane_i} < m_dim) wt_data_o = rd_wt_i;
      for (int b = 0; b < int'(TILE); b++) begin
        if ({1'b0, kh_i, 2'(b)} >= n_dim) begin
          in_data_o[HALF_W-1-DW*b -: DW] = '0;
          wt_data_o[HALF_W-1-DW*b -: DW] = '0;
        end
      end
    end
  end

  // Result rows beyond T are zero; columns beyond M are zeroed within a row.
  always_comb begin
    wdata_o = '0;
    if (wr_i && ({1'b0, ti_i, row_i} < t_dim)) begin
      wdata_o = row_data_i;
      for (int j = 0; j < int'(TILE); j++) begin
        if ({1'b0, mi_i, 2'(j)} >= m_dim) wdata_o[ROW_W-1-AW*j -: AW] = '0;
      end
    end
  end

endmodule

// File: rtl/mac_tile_sched.sv
// Tile sequencer: walks four 4x4 output tiles, loading lanes, accumulating and writing rows.
module mac_tile_sched
  import macarray_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [11:0] MNT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        EN_I,
  output logic [3:0]  ADDR_I,
  input  logic [31:0] RDATA_I,
  output logic        EN_W,
  output logic [3:0]  ADDR_W,
  input  logic [31:0] RDATA_W,
  output logic        EN_O,
  output logic        RW_O,
  output logic [3:0]  ADDR_O,
  output logic [63:0] WDATA_O,
  output logic        ARR_CLR,
  output logic        ARR_LD,
  output logic [1:0]  ARR_LANE,
  output logic [31:0] ARR_I_DATA,
  output logic [31:0] ARR_W_DATA,
  output logic        ARR_ACC,
  output logic [1:0]  ARR_ROW,
  input  logic [63:0] ARR_ROW_DATA
);

  state_t      st_q, st_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        kh_q, kh_d;
  logic        ti_q, ti_d;
  logic        mi_q, mi_d;
  logic        err_q, err_d;
  logic [11:0] mnt_q, mnt_d;

  logic        rd_d, ld_d, wr_d;
  logic [1:0]  lane_d;

  logic        busy_q, done_q, err_o_q, clr_q, ld_q, acc_q;
  logic        en_i_q, en_w_q, en_o_q;
  logic [3:0]  addr_i_q, addr_w_q, addr_o_q;
  logic [1:0]  lane_q, row_q;

  // Next-state: tile loop {mi, ti} with ti inner, two K halves per tile.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    kh_d  = kh_q;
    ti_d  = ti_q;
    mi_d  = mi_q;
    err_d = err_q;
    mnt_d = mnt_q;
    unique case (st_q)
      S_IDLE: begin
        if (START) begin
          mnt_d = MNT;
          cnt_d = '0;
          kh_d  = 1'b0;
          ti_d  = 1'b0;
          mi_d  = 1'b0;
          if (dim_ok(MNT[M_LSB +: DIM_W]) && dim_ok(MNT[N_LSB +: DIM_W]) &&
              dim_ok(MNT[T_LSB +: DIM_W])) begin
            st_d  = S_CLR;
            err_d = 1'b0;
          end else begin
            st_d  = S_DONE;
            err_d = 1'b1;
          end
        end
      end
      S_CLR: begin
        st_d  = S_RD;
        cnt_d = '0;
        kh_d  = 1'b0;
      end
      S_RD: begin
        if (cnt_q == 3'(RD_LAST)) begin
          st_d  = S_ACC;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_ACC: begin
        cnt_d = '0;
        if (!kh_q) begin
          kh_d = 1'b1;
          st_d = S_RD;
        end else begin
          st_d = S_WR;
        end
      end
      S_WR: begin
        if (cnt_q == 3'(WR_LAST)) begin
          cnt_d = '0;
          if (mi_q && ti_q) begin
            st_d = S_DONE;
          end else begin
            st_d = S_CLR;
            ti_d = ~ti_q;
            mi_d = mi_q | ti_q;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE: begin
        st_d  = S_IDLE;
        err_d = 1'b0;
      end
      default: st_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state so every strobe leaves a flop.
  always_comb begin
    rd_d   = (st_d == S_RD) && (cnt_d < 3'(TILE));
    ld_d   = (st_d == S_RD) && (cnt_d != '0);
    wr_d   = (st_d == S_WR);
    lane_d = ld_d ? 2'(cnt_d - 3'd1) : 2'd0;
  end

  // State, loop counters and registered strobes/addresses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q     <= S_IDLE;
      cnt_q    <= '0;
      kh_q     <= 1'b0;
      ti_q     <= 1'b0;
      mi_q     <= 1'b0;
      err_q    <= 1'b0;
      mnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_o_q  <= 1'b0;
      clr_q    <= 1'b0;
      ld_q     <= 1'b0;
      acc_q    <= 1'b0;
      en_i_q   <= 1'b0;
      en_w_q   <= 1'b0;
      en_o_q   <= 1'b0;
      addr_i_q <= '0;
      addr_w_q <= '0;
      addr_o_q <= '0;
      lane_q   <= '0;
      row_q    <= '0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      kh_q     <= kh_d;
      ti_q     <= ti_d;
      mi_q     <= mi_d;
      err_q    <= err_d;
      mnt_q    <= mnt_d;
      busy_q   <= (st_d == S_CLR) || (st_d == S_RD) || (st_d == S_ACC) || (st_d == S_WR);
      done_q   <= (st_d == S_DONE);
      err_o_q  <= (st_d == S_DONE) && err_d;
      clr_q    <= (st_d == S_CLR);
      acc_q    <= (st_d == S_ACC);
      ld_q     <= ld_d;
      lane_q   <= lane_d;
      en_i_q   <= rd_d;
      en_w_q   <= rd_d;
      addr_i_q <= rd_d ? {ti_d, cnt_d[1:0], kh_d} : 4'd0;
      addr_w_q <= rd_d ? {mi_d, cnt_d[1:0], kh_d} : 4'd0;
      en_o_q   <= wr_d;
      row_q    <= wr_d ? cnt_d[1:0] : 2'd0;
      addr_o_q <= wr_d ? {mi_d, ti_d, cnt_d[1:0]} : 4'd0;
    end
  end

  mac_sched_mask u_mask (
    .mnt_i      (mnt_q),
    .ti_i       (ti_q),
    .mi_i       (mi_q),
    .kh_i       (kh_q),
    .lane_i     (lane_q),
    .row_i      (row_q),
    .ld_i       (ld_q),
    .wr_i       (en_o_q),
    .rd_in_i    (RDATA_I),
    .rd_wt_i    (RDATA_W),
    .row_data_i (ARR_ROW_DATA),
    .in_data_o  (ARR_I_DATA),
    .wt_data_o  (ARR_W_DATA),
    .wdata_o    (WDATA_O)
  );

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_o_q;
  assign EN_I     = en_i_q;
  assign ADDR_I   = addr_i_q;
  assign EN_W     = en_w_q;
  assign ADDR_W   = addr_w_q;
  assign EN_O     = en_o_q;
  assign RW_O     = en_o_q;
  assign ADDR_O   = addr_o_q;
  assign ARR_CLR  = clr_q;
  assign ARR_LD   = ld_q;
  assign ARR_LANE = lane_q;
  assign ARR_ACC  = acc_q;
  assign ARR_ROW  = row_q;

endmodule

// File: tb/tb_mac_tile_sched.sv
// Scoreboard bench for mac_tile_sched: driver queues expectations, negedge monitor checks them.
module tb_mac_tile_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [11:0] MNT;
  logic        BUSY, DONE, ERR;
  logic        EN_I, EN_W, EN_O, RW_O;
  logic [3:0]  ADDR_I, ADDR_W, ADDR_O;
  logic [31:0] RDATA_I = '0;
  logic [31:0] RDATA_W = '0;
  logic [63:0] WDATA_O;
  logic        ARR_CLR, ARR_LD, ARR_ACC;
  logic [1:0]  ARR_LANE, ARR_ROW;
  logic [31:0] ARR_I_DATA, ARR_W_DATA;
  logic [63:0] ARR_ROW_DATA;

  mac_tile_sched dut (
    .CLK(CLK), .RST(RST), .START(START), .MNT(MNT),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .EN_I(EN_I), .ADDR_I(ADDR_I), .RDATA_I(RDATA_I),
    .EN_W(EN_W), .ADDR_W(ADDR_W), .RDATA_W(RDATA_W),
    .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .WDATA_O(WDATA_O),
    .ARR_CLR(ARR_CLR), .ARR_LD(ARR_LD), .ARR_LANE(ARR_LANE),
    .ARR_I_DATA(ARR_I_DATA), .ARR_W_DATA(ARR_W_DATA),
    .ARR_ACC(ARR_ACC), .ARR_ROW(ARR_ROW), .ARR_ROW_DATA(ARR_ROW_DATA)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // SRAM images: distinct non-zero bytes everywhere so masking is visible.
  logic [31:0] mem_i [16];
  logic [31:0] mem_w [16];

  always @(posedge CLK) begin
    if (EN_I) RDATA_I <= mem_i[ADDR_I];
    if (EN_W) RDATA_W <= mem_w[ADDR_W];
  end

  function automatic logic [15:0] col_val(input int j, input int r);
    return 16'(4096 * (j + 1) + r + 1);
  endfunction

  // Stand-in array: each selected row carries a recognisable per-column pattern.
  always_comb begin
    ARR_ROW_DATA = '0;
    for (int j = 0; j < 4; j++) ARR_ROW_DATA[63-16*j -: 16] = col_val(j, int'(ARR_ROW));
  end

  typedef struct packed {
    logic [1:0]  lane;
    logic [31:0] idat;
    logic [31:0] wdat;
  } ld_t;

  typedef struct packed {
    logic [3:0]  addr;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    logic err;
    int   cyc;
    int   busy;
    int   act;
    int   acc;
  } done_t;

  typedef struct {
    int cyc;
    int kind;
  } req_t;

  localparam int K_ZERO  = 0;
  localparam int K_ABORT = 1;
  localparam int K_END   = 2;

  ld_t   ldq[$];
  wr_t   wrq[$];
  done_t dq[$];
  req_t  rq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_lane(input logic [31:0] src, input int idx, input int lim,
                                           input int kh, input int n);
    logic [31:0] r;
    r = '0;
    if (idx < lim)
      for (int b = 0; b < 4; b++)
        if (kh * 4 + b < n) r[31-8*b -: 8] = src[31-8*b -: 8];
    return r;
  endfunction

  function automatic logic [63:0] exp_row(input int mi, input int ti, input int r,
                                          input int m, input int t);
    logic [63:0] d;
    d = '0;
    if (ti * 4 + r < t)
      for (int j = 0; j < 4; j++)
        if (mi * 4 + j < m) d[63-16*j -: 16] = col_val(j, r);
    return d;
  endfunction

  task automatic post(input int c, input int k);
    req_t q;
    q.cyc  = c;
    q.kind = k;
    rq.push_back(q);
  endtask

  // Queue the full expected response of one job.
  task automatic push_job(input logic [11:0] mnt, input int done_cyc, input bit with_done);
    int m, n, t;
    bit ok;
    ld_t   l;
    wr_t   w;
    done_t d;
    m  = int'(mnt[11:8]);
    n  = int'(mnt[7:4]);
    t  = int'(mnt[3:0]);
    ok = (m >= 1 && m <= 8) && (n >= 1 && n <= 8) && (t >= 1 && t <= 8);
    if (ok) begin
      for (int mi = 0; mi < 2; mi++)
        for (int ti = 0; ti < 2; ti++) begin
          for (int kh = 0; kh < 2; kh++)
            for (int ln = 0; ln < 4; ln++) begin
              l.lane = 2'(ln);
              l.idat = exp_lane(mem_i[(ti*4+ln)*2+kh], ti*4+ln, t, kh, n);
              l.wdat = exp_lane(mem_w[(mi*4+ln)*2+kh], mi*4+ln, m, kh, n);
              ldq.push_back(l);
            end
          for (int r = 0; r < 4; r++) begin
            w.addr = 4'(mi*8 + ti*4 + r);
            w.data = exp_row(mi, ti, r, m, t);
            wrq.push_back(w);
          end
        end
    end
    if (with_done) begin
      d.err  = !ok;
      d.cyc  = done_cyc;
      d.busy = ok ? 68 : 0;
      d.act  = ok ? 68 : 0;
      d.acc  = ok ? 8 : 0;
      dq.push_back(d);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  // Monitor: all comparisons happen here, sampled on the falling edge.
  int   busy_n = 0, act_n = 0, acc_n = 0;
  logic prev_en_i = 1'b0, prev_en_w = 1'b0;
  logic [3:0] prev_addr_i = '0, prev_addr_w = '0;

  always @(negedge CLK) begin
    ld_t   l;
    wr_t   w;
    done_t d;
    if (BUSY) busy_n++;
    if (EN_I || EN_W || EN_O || ARR_CLR || ARR_LD || ARR_ACC) act_n++;
    if (ARR_ACC) acc_n++;

    if (ARR_LD) begin
      chk("ld_lag_i", 128'({prev_en_i, prev_addr_i[2:1]}), 128'({1'b1, ARR_LANE}));
      chk("ld_lag_w", 128'({prev_en_w, prev_addr_w[2:1]}), 128'({1'b1, ARR_LANE}));
      if (ldq.size() == 0) chk("ld_unexpected", 128'(1), 128'(0));
      else begin
        l = ldq.pop_front();
        chk("ld_lane", 128'(ARR_LANE), 128'(l.lane));
        chk("ld_idata", 128'(ARR_I_DATA), 128'(l.idat));
        chk("ld_wdata", 128'(ARR_W_DATA), 128'(l.wdat));
      end
    end

    if (EN_O) begin
      chk("wr_rw", 128'(RW_O), 128'(1));
      if (wrq.size() == 0) chk("wr_unexpected", 128'(1), 128'(0));
      else begin
        w = wrq.pop_front();
        chk("wr_addr", 128'(ADDR_O), 128'(w.addr));
        chk("wr_data", 128'(WDATA_O), 128'(w.data));
      end
    end

    if (DONE) begin
      if (dq.size() == 0) chk("done_unexpected", 128'(1), 128'(0));
      else begin
        d = dq.pop_front();
        chk("done_err", 128'(ERR), 128'(d.err));
        chk("done_cycle", 128'(cyc), 128'(d.cyc));
        chk("busy_cycles", 128'(busy_n), 128'(d.busy));
        chk("active_cycles", 128'(act_n), 128'(d.act));
        chk("acc_pulses", 128'(acc_n), 128'(d.acc));
      end
      busy_n = 0;
      act_n  = 0;
      acc_n  = 0;
    end

    while (rq.size() > 0 && rq[0].cyc <= cyc) begin
      case (rq[0].kind)
        K_ZERO: begin
          chk("idle_ctrl", 128'({BUSY, DONE, ERR, EN_I, ADDR_I, EN_W, ADDR_W, EN_O, RW_O, ADDR_O,
                                 ARR_CLR, ARR_LD, ARR_LANE, ARR_ACC, ARR_ROW}), 128'(0));
          chk("idle_data", 128'({WDATA_O, ARR_I_DATA, ARR_W_DATA}), 128'(0));
        end
        K_ABORT: begin
          chk("abort_loads_left", 128'(ldq.size()), 128'(22));
          chk("abort_writes_left", 128'(wrq.size()), 128'(12));
          ldq.delete();
          wrq.delete();
          busy_n = 0;
          act_n  = 0;
          acc_n  = 0;
        end
        default: begin
          chk("end_loads_left", 128'(ldq.size()), 128'(0));
          chk("end_writes_left", 128'(wrq.size()), 128'(0));
          chk("end_dones_left", 128'(dq.size()), 128'(0));
          $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
          $finish;
        end
      endcase
      void'(rq.pop_front());
    end

    prev_en_i   = EN_I;
    prev_en_w   = EN_W;
    prev_addr_i = ADDR_I;
    prev_addr_w = ADDR_W;
  end

  // Driver: directed jobs; each START raised at a known cycle x.
  initial begin
    int x;
    RST   = 1'b1;
    START = 1'b0;
    MNT   = '0;
    for (int a = 0; a < 16; a++) begin
      mem_i[a] = {8'(16*a+1), 8'(16*a+2), 8'(16*a+3), 8'(16*a+4)};
      mem_w[a] = ~mem_i[a];
    end

    wait_to(2);
    post(3, K_ZERO);
    wait_to(4);
    RST = 1'b0;

    // Full size, START held: two back-to-back jobs.
    wait_to(6);
    x     = cyc;
    MNT   = 12'h888;
    START = 1'b1;
    push_job(12'h888, x + 69, 1'b1);
    push_job(12'h888, x + 139, 1'b1);
    wait_to(x + 139);
    START = 1'b0;

    // 6x6x6: partial lanes, bytes and columns.
    wait_to(x + 145);
    x     = cyc;
    MNT   = 12'h666;
    START = 1'b1;
    push_job(12'h666, x + 69, 1'b1);
    @(negedge CLK);
    START = 1'b0;

    // 1x1x1, with a stray START (and changed MNT) mid-job.
    wait_to(x + 75);
    x     = cyc;
    MNT   = 12'h111;
    START = 1'b1;
    push_job(12'h111, x + 69, 1'b1);
    @(negedge CLK);
    START = 1'b0;
    wait_to(x + 30);
    MNT   = 12'h066;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;

    // M=0: immediate rejection.
    wait_to(x + 80);
    x     = cyc;
    START = 1'b1;
    push_job(12'h066, x + 1, 1'b1);
    @(negedge CLK);
    START = 1'b0;

    // Abort during tile 1 RD cnt 2, then a clean rerun.
    wait_to(x + 5);
    x     = cyc;
    MNT   = 12'h888;
    START = 1'b1;
    push_job(12'h888, 0, 1'b0);
    @(negedge CLK);
    START = 1'b0;
    wait_to(x + 21);
    RST = 1'b1;
    post(x + 22, K_ZERO);
    post(x + 22, K_ABORT);
    wait_to(x + 22);
    RST = 1'b0;

    wait_to(x + 24);
    x     = cyc;
    START = 1'b1;
    push_job(12'h888, x + 69, 1'b1);
    @(negedge CLK);
    START = 1'b0;

    wait_to(x + 75);
    post(x + 76, K_END);
    wait_to(x + 90);
    $display("FAIL end_of_run: summary not reached by cycle %0d", cyc);
    $fatal(1);
  end

endmodule
